// File: rtl/rv32imf_rr_arbiter.sv
// Round-robin arbiter that grants one requester access to a shared resource.
// It issues a start handshake, holds the grant until done or timeout, then rotates priority.
module rv32imf_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    input  logic                       res_done_i,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // A zero-width counter is illegal, so keep one bit when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_found;
    logic             release_grant;
    logic [IDX_W-1:0] ptr_next;

    // Prefer the lowest request at or above the pointer, else wrap to the lowest overall.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_idx = IDX_W'(i);
                if (i >= int'(ptr_q)) begin
                    hi_idx   = IDX_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    assign ptr_next = (gnt_idx_o == IDX_LAST) ? '0 : gnt_idx_o + IDX_W'(1);

    always_comb begin
        state_d       = state_q;
        res_valid_o   = 1'b0;
        timeout_o     = 1'b0;
        release_grant = 1'b0;
        busy_o        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Done wins over a coinciding timeout, so no pulse is raised then.
                if (res_done_i) begin
                    state_d       = IDLE;
                    release_grant = 1'b1;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    release_grant = 1'b1;
                    timeout_o     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_o     <= '0;
            gnt_idx_o <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |req_i) begin
                gnt_idx_o <= win_idx;
                gnt_o     <= NUM_REQ'(1) << win_idx;
            end
            if (release_grant) begin
                gnt_o <= '0;
                ptr_q <= ptr_next;
            end
            // Counter is held at zero while issuing so it starts clean on BUSY entry.
            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == BUSY && state_d == BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/rv32imf_rr_arbiter.md
RV32IMF_RR_ARBITER -- requirements
Module: rv32imf_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..32.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum BUSY cycles before forced release; 0 disables the timeout.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_i, input, NUM_REQ bits: per-requester request level.
REQ-006 SHALL have port gnt_o, output, NUM_REQ bits: one-hot grant, registered.
REQ-007 SHALL have port gnt_idx_o, output, $clog2(NUM_REQ) bits: binary index of current grantee, registered.
REQ-008 SHALL have port res_valid_o, output, 1 bit: start strobe to the shared resource.
REQ-009 SHALL have port res_ready_i, input, 1 bit: resource accepts the start.
REQ-010 SHALL have port res_done_i, input, 1 bit: resource finished the current operation.
REQ-011 SHALL have port busy_o, output, 1 bit: high in ISSUE or BUSY.
REQ-012 SHALL have port timeout_o, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE and BUSY, with IDLE as the reset state.
REQ-014 SHALL hold a priority pointer ptr_q, width $clog2(NUM_REQ), reset value 0.
REQ-015 Arbitration SHALL select the lowest set req_i index >= ptr_q; if there is none, the lowest set index overall (wrap-around); ties are impossible by construction.
REQ-016 In IDLE with any req_i bit set at cycle t: SHALL latch the winner, enter ISSUE at t+1, and drive gnt_o/gnt_idx_o valid from t+1 (1-cycle latency).
REQ-017 In IDLE with req_i == 0: SHALL remain in IDLE with gnt_o = 0.
REQ-018 In ISSUE: res_valid_o SHALL be 1; on res_ready_i = 1, SHALL enter BUSY next cycle; otherwise SHALL remain in ISSUE.
REQ-019 In ISSUE or BUSY the grant SHALL be locked: changes to req_i (including the grantee dropping its request) SHALL be ignored.
REQ-020 res_done_i SHALL be ignored outside BUSY.
REQ-021 In BUSY: res_valid_o SHALL be 0; on res_done_i = 1, SHALL set ptr_q = (gnt_idx + 1) mod NUM_REQ, enter IDLE, and clear gnt_o the next cycle.
REQ-022 No grant SHALL be issued in the cycle the FSM enters IDLE; re-arbitration occurs in IDLE, giving a minimum gap of 1 idle cycle between grants.
REQ-023 A BUSY cycle counter SHALL clear on BUSY entry and increment each BUSY cycle without res_done_i; its width is $clog2(TIMEOUT+1).
REQ-024 When TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no res_done_i: timeout_o SHALL pulse for that cycle, ptr_q SHALL advance as in REQ-021, and the FSM SHALL enter IDLE.
REQ-025 When res_done_i and the timeout condition coincide: done SHALL take precedence and timeout_o SHALL stay 0.
REQ-026 gnt_o SHALL equal the one-hot decode of gnt_idx_o whenever busy_o = 1, and be 0 otherwise.

Reset
REQ-027 When rst_i = 1 at a clock edge: the FSM SHALL go to IDLE; ptr_q, the counter, gnt_o, gnt_idx_o, res_valid_o, busy_o and timeout_o SHALL be 0 from the next cycle.
REQ-028 Reset SHALL take precedence over every other event, including mid-ISSUE or mid-BUSY; no pointer update SHALL occur on reset.

Verification (NUM_REQ = 4, TIMEOUT = 8)
REQ-029 Reset then req_i = 4'b1010 -> next cycle gnt_o = 4'b0010, gnt_idx_o = 1, res_valid_o = 1.
REQ-030 req_i held at 4'b1111, res_ready_i = 1, res_done_i after 2 BUSY cycles -> grant sequence 0,1,2,3,0, one idle cycle between each.
REQ-031 After granting index 2 (ptr_q = 3), req_i = 4'b0011 -> grant index 0 (wrap-around).
REQ-032 res_ready_i held 0 for 5 cycles while the grantee drops req -> stays in ISSUE with gnt_o unchanged; BUSY entered the cycle after res_ready_i = 1.
REQ-033 BUSY with no res_done_i -> timeout_o = 1 on the 8th BUSY cycle, IDLE next, ptr_q advanced; with res_done_i also on the 8th cycle, timeout_o = 0.
REQ-034 rst_i pulse in BUSY with gnt_idx_o = 2 -> all outputs 0 next cycle, ptr_q = 0; then req_i = 4'b1111 -> grant index 0.
